// File: rtl/mux_sync_mc.sv
// mux_sync_mc: per-channel CDC capture with synchronised control, mux-recirculation data register and sticky overrun
module mux_sync_mc #(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TOGGLE_MODE = 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]            ctrl_i,
  input  logic [NUM_CH-1:0]            rdy_i,
  input  logic                         clr_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            vld_o,
  output logic [NUM_CH-1:0]            ack_o,
  output logic [NUM_CH-1:0]            ovf_o
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_N = AW'(SYNC_STAGES + 1);
  typedef enum logic {IDLE, FULL} state_t;
  logic [AW-1:0] arm_q;
  logic armed;
  assign armed = arm_q == ARM_N;
  // Events are ignored until the sync chains have flushed the level seen at reset release
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) arm_q <= '0;
    else if (!armed) arm_q <= arm_q + 1'b1;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DATA_WIDTH-1:0] din, data_q;
    logic ctrl_s, ctrl_d, evt, ld, ovr, vld_q, ovf_q;
    state_t st, st_nxt;
    assign din = data_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign ctrl_s = sync_q[SYNC_STAGES-1];
    assign evt = armed & (TOGGLE_MODE != 0 ? ctrl_s ^ ctrl_d : ctrl_s & ~ctrl_d);
    assign ld = evt & ((st == IDLE) | rdy_i[c]);
    assign ovr = evt & (st == FULL) & ~rdy_i[c];
    assign st_nxt = ld ? FULL : (st == FULL && rdy_i[c]) ? IDLE : st;
    always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
        sync_q <= '0;
        ctrl_d <= 1'b0;
        data_q <= '0;
        st     <= IDLE;
        vld_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], ctrl_i[c]};
        ctrl_d <= ctrl_s;
        data_q <= ld ? din : data_q;
        st     <= st_nxt;
        vld_q  <= st_nxt == FULL;
        ovf_q  <= ovr | (ovf_q & ~clr_i);
      end
    assign data_o[c*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign vld_o[c] = vld_q;
    assign ack_o[c] = ctrl_d;
    assign ovf_o[c] = ovf_q;
  end
endmodule

// File: tb/tb_mux_sync_mc.sv
// tb_mux_sync_mc: vector table, hand sequences and randomised scoreboard for mux_sync_mc
module tb_mux_sync_mc;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [63:0] data_a = '0;
  logic [1:0] ctrl_a = '0, rdy_a = '0;
  logic clr_a = 1'b0;
  logic [63:0] do_a;
  logic [1:0] vld_a, ack_a, ovf_a;
  logic [7:0] data_b = '0;
  logic ctrl_b = 1'b0, rdy_b = 1'b0, clr_b = 1'b0;
  logic [7:0] do_b;
  logic vld_b, ack_b, ovf_b;
  logic [127:0] data_c = '0;
  logic [3:0] ctrl_c = '0, rdy_c = '0;
  logic clr_c = 1'b0;
  logic [127:0] do_c;
  logic [3:0] vld_c, ack_c, ovf_c;
  mux_sync_mc dut_a (
    .clk_i(clk), .rstn_i(rstn), .data_i(data_a), .ctrl_i(ctrl_a), .rdy_i(rdy_a), .clr_i(clr_a),
    .data_o(do_a), .vld_o(vld_a), .ack_o(ack_a), .ovf_o(ovf_a)
  );
  mux_sync_mc #(.NUM_CH(1), .DATA_WIDTH(8), .SYNC_STAGES(2), .TOGGLE_MODE(0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .data_i(data_b), .ctrl_i(ctrl_b), .rdy_i(rdy_b), .clr_i(clr_b),
    .data_o(do_b), .vld_o(vld_b), .ack_o(ack_b), .ovf_o(ovf_b)
  );
  mux_sync_mc #(.NUM_CH(4), .DATA_WIDTH(32), .SYNC_STAGES(3), .TOGGLE_MODE(1)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .data_i(data_c), .ctrl_i(ctrl_c), .rdy_i(rdy_c), .clr_i(clr_c),
    .data_o(do_c), .vld_o(vld_c), .ack_o(ack_c), .ovf_o(ovf_c)
  );
  typedef struct packed {
    logic ctrl, rdy, clr;
    logic [31:0] din;
    logic vld, ack, ovf;
    logic [31:0] dout;
  } vec_t;
  vec_t tbl [20];
  int n_tests = 0, n_fail = 0;
  int vcnt;
  logic saw_vld;
  logic [31:0] m_data [4], p_data [4];
  logic m_vld [4], m_ack [4], m_ovf [4], p_lvl [4];
  int due [4];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic c, r, l, input logic [31:0] d, input logic ev, ea, eo, input logic [31:0] ed);
    return {c, r, l, d, ev, ea, eo, ed};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    //            ctrl rdy clr din            vld ack ovf dout
    tbl[0]  = mk(1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 1, 0, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF);
    tbl[3]  = mk(1, 1, 0, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0, 0, 32'hA5A5A5A5, 0, 1, 0, 32'hDEADBEEF);
    tbl[5]  = mk(0, 0, 0, 32'hA5A5A5A5, 0, 1, 0, 32'hDEADBEEF);
    tbl[6]  = mk(0, 0, 0, 32'hA5A5A5A5, 1, 0, 0, 32'hA5A5A5A5);
    tbl[7]  = mk(1, 0, 0, 32'h55, 1, 0, 0, 32'hA5A5A5A5);
    tbl[8]  = mk(1, 0, 0, 32'h55, 1, 0, 0, 32'hA5A5A5A5);
    tbl[9]  = mk(1, 1, 0, 32'h55, 1, 1, 0, 32'h55);
    tbl[10] = mk(1, 0, 0, 32'h55, 1, 1, 0, 32'h55);
    tbl[11] = mk(0, 0, 0, 32'h66, 1, 1, 0, 32'h55);
    tbl[12] = mk(0, 0, 0, 32'h66, 1, 1, 0, 32'h55);
    tbl[13] = mk(0, 0, 0, 32'h66, 1, 0, 1, 32'h55);
    tbl[14] = mk(0, 0, 1, 32'h66, 1, 0, 0, 32'h55);
    tbl[15] = mk(1, 0, 0, 32'h77, 1, 0, 0, 32'h55);
    tbl[16] = mk(1, 0, 1, 32'h77, 1, 0, 0, 32'h55);
    tbl[17] = mk(1, 0, 1, 32'h77, 1, 1, 1, 32'h55);
    tbl[18] = mk(1, 0, 0, 32'h77, 1, 1, 1, 32'h55);
    tbl[19] = mk(1, 1, 0, 32'h77, 0, 1, 1, 32'h55);
    data_a = 64'h0123456789ABCDEF;
    repeat (2) tick;
    check("reset_a", {do_a, vld_a, ack_a, ovf_a}, 64'd0);
    check("reset_c", {vld_c, ack_c, ovf_c, do_c[31:0]}, 64'd0);
    #2;
    rstn = 1'b1;
    data_a = {32'hCAFEF00D, 32'h0};
    repeat (6) tick;
    for (int i = 0; i < 20; i++) begin
      ctrl_a[0] = tbl[i].ctrl;
      rdy_a[0] = tbl[i].rdy;
      clr_a = tbl[i].clr;
      data_a[31:0] = tbl[i].din;
      tick;
      check($sformatf("vec%0d_ch0", i), {vld_a[0], ack_a[0], ovf_a[0], do_a[31:0]},
            {tbl[i].vld, tbl[i].ack, tbl[i].ovf, tbl[i].dout});
      check($sformatf("vec%0d_ch1_idle", i), {vld_a[1], ack_a[1], ovf_a[1], do_a[63:32]}, 64'd0);
    end
    clr_a = 1'b0;
    rdy_a[1] = 1'b0;
    data_a[63:32] = 32'h11;
    ctrl_a[1] = 1'b1;
    repeat (6) tick;
    check("ovr_first", {vld_a[1], ack_a[1], ovf_a[1], do_a[63:32]}, {1'b1, 1'b1, 1'b0, 32'h11});
    data_a[63:32] = 32'h22;
    ctrl_a[1] = 1'b0;
    repeat (6) tick;
    check("ovr_drop", {vld_a[1], ack_a[1], ovf_a[1], do_a[63:32]}, {1'b1, 1'b0, 1'b1, 32'h11});
    check("ovr_ch0_iso", {vld_a[0], ack_a[0], ovf_a[0], do_a[31:0]}, {1'b0, 1'b1, 1'b1, 32'h55});
    clr_a = 1'b1;
    tick;
    clr_a = 1'b0;
    check("ovr_clr", ovf_a, 2'b00);
    tick;
    check("ovr_clr_hold", {vld_a[1], ovf_a[1], do_a[63:32]}, {1'b1, 1'b0, 32'h11});
    data_b = 8'h3C;
    rdy_b = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      ctrl_b = (i < 4);
      tick;
      if (vld_b) begin
        vcnt++;
        check("lvl_data", do_b, 8'h3C);
      end
    end
    check("lvl_one_capture", vcnt, 1);
    check("lvl_ack_low", ack_b, 0);
    ctrl_a[1] = 1'b1;
    tick;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_a", {do_a, vld_a, ack_a, ovf_a}, 64'd0);
    check("async_rst_b", {do_b, vld_b, ack_b, ovf_b}, 64'd0);
    repeat (2) tick;
    check("rst_hold_a", {vld_a, ack_a, ovf_a}, 64'd0);
    #2;
    rstn = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (vld_a != 2'b00) saw_vld = 1'b1;
      if (i == 1) check("arm_ack_early", ack_a, 2'b00);
      if (i == 2) check("arm_ack", ack_a, 2'b11);
    end
    check("arm_no_vld", saw_vld, 1'b0);
    for (int k = 0; k < 4; k++) begin
      m_data[k] = '0;
      m_vld[k] = 1'b0;
      m_ack[k] = 1'b0;
      m_ovf[k] = 1'b0;
      due[k] = -1;
    end
    for (int n = 0; n < 1500; n++) begin
      #($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) begin
        rdy_c[k] = ($urandom_range(0, 2) != 0);
        if (due[k] < 0 && n < 1490 && $urandom_range(0, 3) == 0) begin
          p_data[k] = $urandom;
          data_c[k*32 +: 32] = p_data[k];
          ctrl_c[k] = ~ctrl_c[k];
          p_lvl[k] = ctrl_c[k];
          due[k] = n + 3;
        end else if (due[k] < 0 && $urandom_range(0, 3) == 0) begin
          data_c[k*32 +: 32] = $urandom;
        end
      end
      clr_c = ($urandom_range(0, 19) == 0);
      tick;
      for (int k = 0; k < 4; k++) begin
        logic ev, drop;
        ev = (due[k] == n);
        drop = ev && m_vld[k] && !rdy_c[k];
        if (ev && !drop) begin
          m_data[k] = p_data[k];
          m_vld[k] = 1'b1;
        end else if (!ev && m_vld[k] && rdy_c[k]) begin
          m_vld[k] = 1'b0;
        end
        m_ovf[k] = drop | (m_ovf[k] & ~clr_c);
        if (ev) begin
          m_ack[k] = p_lvl[k];
          due[k] = -1;
        end
        check($sformatf("rand_n%0d_ch%0d", n, k), {vld_c[k], ack_c[k], ovf_c[k], do_c[k*32 +: 32]},
              {m_vld[k], m_ack[k], m_ovf[k], m_data[k]});
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_sync_mc.md
MUX_SYNC_MC -- requirements
Module: mux_sync_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent synchronised channels (>=1).
REQ-002 Parameter DATA_WIDTH, default 32: data bits per channel (>=1).
REQ-003 Parameter SYNC_STAGES, default 2: flops in each control synchroniser chain (>=2).
REQ-004 Parameter TOGGLE_MODE, default 1: 1 = one transfer per ctrl_i edge (either polarity); 0 = one transfer per ctrl_i rising edge (4-phase level).
REQ-005 clk_i  in  1  destination-domain clock; all outputs are synchronous to it.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 data_i  in  NUM_CH*DATA_WIDTH  source-domain data; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH]; the source holds it stable from its ctrl_i change until it sees the ack_o change.
REQ-008 ctrl_i  in  NUM_CH  asynchronous per-channel transfer control.
REQ-009 rdy_i  in  NUM_CH  downstream consumer ready, per channel.
REQ-010 clr_i  in  1  synchronous clear of all ovf_o bits.
REQ-011 data_o  out  NUM_CH*DATA_WIDTH  captured data per channel, same packing as data_i.
REQ-012 vld_o  out  NUM_CH  captured data valid, per channel.
REQ-013 ack_o  out  NUM_CH  acknowledge to the source domain, per channel.
REQ-014 ovf_o  out  NUM_CH  sticky overrun flag, per channel.

Function
REQ-015 Each ctrl_i[k] passes through a SYNC_STAGES-flop chain; ctrl_s[k] is the last stage and ctrl_d[k] is ctrl_s[k] delayed one cycle.
REQ-016 An event is ctrl_s^ctrl_d when TOGGLE_MODE=1, and ctrl_s&~ctrl_d when TOGGLE_MODE=0.
REQ-017 Capture is a mux-recirculation register: data_o[k] loads data_i[k] only on an accepted event and otherwise holds its value; data_i is never routed combinationally to data_o.
REQ-018 Latency: ctrl_i changes before edge 0, the event is visible after edge SYNC_STAGES-1, and data_o/vld_o update at edge SYNC_STAGES (edge 2 for the default).
REQ-019 Per-channel FSM IDLE (vld_o=0) / FULL (vld_o=1); IDLE+event -> capture, FULL.
REQ-020 FULL & rdy_i & no event -> IDLE; FULL & ~rdy_i & no event -> FULL, data_o held.
REQ-021 FULL & rdy_i & event (simultaneous) -> capture the new data, stay FULL, no overrun.
REQ-022 FULL & ~rdy_i & event -> event dropped, data_o unchanged, ovf_o[k] set next edge.
REQ-023 ovf_o is sticky until clr_i; if clr_i and a new overrun occur in the same cycle, ovf_o is 1 (set wins).
REQ-024 ack_o[k] = ctrl_d[k] (registered) and updates for every event, accepted or dropped, so the source never deadlocks.
REQ-025 Channels are fully independent; activity on one channel never alters another channel's outputs.

Reset
REQ-026 rstn_i low: all sync stages, ctrl_d, data_o, vld_o, ack_o and ovf_o = 0 immediately, including mid-transfer.
REQ-027 An arming counter masks events for SYNC_STAGES+1 cycles after rstn_i deasserts; ctrl_d tracks ctrl_s while masked, so a ctrl_i held high through reset produces no event and no vld_o.
REQ-028 The FSM leaves IDLE only on an unmasked event.

Verification
REQ-029 Defaults, ch0 data_i=0xDEADBEEF, ctrl_i[0] 0->1 before edge 0, rdy_i=1 -> vld_o[0]=1 and data_o[0]=0xDEADBEEF after edge 2, ack_o[0]=1 after edge 2, vld_o[0]=0 after edge 3.
REQ-030 TOGGLE_MODE=1, rdy_i=0, toggle ctrl_i[1] twice with data 0x11 then 0x22, spaced 6 cycles -> data_o[1]=0x11, vld_o[1]=1, ovf_o[1]=1, ack_o[1] follows both toggles; clr_i pulse -> ovf_o[1]=0.
REQ-031 TOGGLE_MODE=0, ctrl_i pulse 1 then 0 -> exactly one capture; the falling edge produces no vld_o.
REQ-032 FULL with rdy_i=1 in the same cycle as a new event (data 0x55) -> data_o=0x55, vld_o stays 1, ovf_o stays 0.
REQ-033 ctrl_i[0]=1 held through reset release -> no vld_o and ack_o[0]=1 within SYNC_STAGES+1 cycles; rstn_i asserted mid-transfer -> all outputs 0 with no clock edge.
REQ-034 NUM_CH=4, SYNC_STAGES=3, random asynchronous ctrl_i/rdy_i against a scoreboard -> per-channel ordering and data match, latency 3 edges, ovf_o exactly on drops.
